// File: rtl/ahb_ram_bridge.sv
// ahb_ram_bridge: AHB-Lite slave that owns the port of a single-port,
// 1-cycle registered-read word SRAM. Byte/halfword writes become masked word
// writes. Reads are zero-wait. A read whose address phase lands on a write
// data phase is delayed by one wait state, because both need the RAM port.
module ahb_ram_bridge #(
  parameter int ADDR_W = 13
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wmask,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_RDSTALL = 3'd3,
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5
  } state_t;

  // Flags an illegal size or a misaligned half/word access.
  function automatic logic size_align_err(input logic [2:0] size, input logic [1:0] lsb);
    logic err;
    case (size)
      3'd0:    err = 1'b0;
      3'd1:    err = lsb[0];
      3'd2:    err = (lsb != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Builds the per-bit keep mask: 0 on bits of the enabled byte lanes.
  function automatic logic [31:0] lane_keep_mask(input logic [1:0] size, input logic [1:0] lsb);
    logic [3:0] en;
    case (size)
      2'd0:    en = 4'b0001 << lsb;
      2'd1:    en = lsb[1] ? 4'b1100 : 4'b0011;
      2'd2:    en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return ~{{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_wsize;
  logic [1:0]          r_wlsb;
  logic                r_hreadyout;
  logic                r_hresp;
  logic                r_rd_phase;

  logic                w_can_accept;
  logic                w_acc;
  logic                w_err;
  logic                w_rd_acc;
  logic                w_unused_haddr;

  // Upper address bits alias the window and are deliberately ignored.
  assign w_unused_haddr = ^HADDR[31:ADDR_W+2];

  // ERR1 and RDSTALL hold HREADYOUT low, so nothing can be accepted there.
  assign w_can_accept = (r_state != ST_ERR1) && (r_state != ST_RDSTALL);
  assign w_acc        = HSEL & HTRANS[1] & HREADY & w_can_accept;
  assign w_err        = size_align_err(HSIZE, HADDR[1:0]);
  // Read that can use the RAM port right away in its address phase.
  assign w_rd_acc     = w_acc & ~w_err & ~HWRITE & (r_state != ST_WR);

  // Next-state decode for the data-phase FSM.
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_ERR1:    w_next_state = ST_ERR2;
      ST_RDSTALL: w_next_state = ST_RD;
      ST_IDLE, ST_RD, ST_WR, ST_ERR2: begin
        if (w_acc) begin
          if (w_err) begin
            w_next_state = ST_ERR1;
          end else if (HWRITE) begin
            w_next_state = ST_WR;
          end else if (r_state == ST_WR) begin
            w_next_state = ST_RDSTALL;
          end else begin
            w_next_state = ST_RD;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Captures the word address of any good transfer (used by WR and RDSTALL)
  // and the size/byte offset of writes for the lane mask.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_addr  <= {ADDR_W{1'b0}};
      r_wsize <= 2'b00;
      r_wlsb  <= 2'b00;
    end else if (w_acc && !w_err) begin
      r_addr <= HADDR[ADDR_W+1:2];
      if (HWRITE) begin
        r_wsize <= HSIZE[1:0];
        r_wlsb  <= HADDR[1:0];
      end
    end
  end

  // Bus response flags, registered from the state being entered.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_rd_phase  <= 1'b0;
    end else begin
      r_hreadyout <= (w_next_state != ST_RDSTALL) && (w_next_state != ST_ERR1);
      r_hresp     <= (w_next_state == ST_ERR1) || (w_next_state == ST_ERR2);
      r_rd_phase  <= (w_next_state == ST_RD);
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_rd_phase ? ram_rdata : 32'h0000_0000;
  assign ram_wdata = HWDATA;

  // RAM port arbitration: a pending write data phase wins, then a stalled
  // read, then a read in its own address phase. Reset gates all strobes.
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = HADDR[ADDR_W+1:2];
    ram_wmask = 32'hFFFF_FFFF;
    if (HRESET) begin
      ram_cs = 1'b0;
      ram_we = 1'b0;
    end else if (r_state == ST_WR) begin
      ram_cs    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = r_addr;
      ram_wmask = lane_keep_mask(r_wsize, r_wlsb);
    end else if (r_state == ST_RDSTALL) begin
      ram_cs   = 1'b1;
      ram_addr = r_addr;
    end else if (w_rd_acc) begin
      ram_cs   = 1'b1;
      ram_addr = HADDR[ADDR_W+1:2];
    end else begin
      ram_cs = 1'b0;
      ram_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_ram_bridge.sv
// Bench for ahb_ram_bridge: directed cases plus random traffic. The driver
// pushes expected responses; a negedge monitor pops and checks them.
module tb_ahb_ram_bridge;
  localparam int ADDR_W = 13;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wmask;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  ahb_ram_bridge #(.ADDR_W(ADDR_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;   // single slave on the bus

  // SRAM stand-in: 1-cycle registered read, bit-masked write.
  logic [31:0] ram_model [0:(1<<ADDR_W)-1];
  always @(posedge HCLK) begin
    if (ram_cs && !ram_we) ram_rdata <= ram_model[ram_addr];
    else                   ram_rdata <= 32'h0;
    if (ram_cs && ram_we)
      ram_model[ram_addr] <= (ram_model[ram_addr] & ram_wmask) | (ram_wdata & ~ram_wmask);
  end

  typedef struct {
    logic        wr;
    logic        err;
    logic [12:0] idx;
    logic [31:0] mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_wr_cyc = -10;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic is_err(input logic [2:0] size, input logic [1:0] lo);
    if (size > 3'd2) return 1'b1;
    return (int'(lo) % (1 << int'(size))) != 0;
  endfunction

  function automatic logic [31:0] keep_mask(input logic [2:0] size, input logic [1:0] lo);
    logic [31:0] m;
    int nbytes, first;
    m = 32'hFFFF_FFFF;
    if (size > 3'd2) return m;
    nbytes = 1 << int'(size);
    first  = (int'(lo) / nbytes) * nbytes;
    for (int b = first; b < first + nbytes; b++) m[8*b +: 8] = 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [12:0] i);
    if (ref_mem.exists(int'(i))) return ref_mem[int'(i)];
    return 32'h0;
  endfunction

  // Presents one transfer, waits for it to be accepted, updates the model.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, input logic seq);
    logic rdy;
    int   guard;
    exp_t e;
    HSEL = 1'b1; HADDR = addr; HTRANS = seq ? 2'b11 : 2'b10; HWRITE = wr; HSIZE = size;
    rdy = 1'b0; guard = 0;
    while (!rdy && guard < 8) begin
      @(negedge HCLK); rdy = HREADY;
      @(posedge HCLK); #1;
      guard++;
    end
    if (!rdy) begin
      chk("accept_timeout", 32'(rdy), 32'h1);
    end else begin
      e.wr = wr; e.err = is_err(size, addr[1:0]); e.idx = addr[14:2];
      e.mask = keep_mask(size, addr[1:0]); e.wdata = wd; e.rdata = 32'h0;
      if (e.err) e.waits = 1;
      else if (!wr && last_wr_cyc == cyc - 1) e.waits = 1;
      else e.waits = 0;
      if (!e.err) begin
        if (wr) ref_mem[int'(e.idx)] = (ref_rd(e.idx) & e.mask) | (wd & ~e.mask);
        else    e.rdata = ref_rd(e.idx);
      end
      last_wr_cyc = (wr && !e.err) ? cyc : -10;
      sb.push_back(e);
      if (wr) HWDATA = wd;
    end
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  // Cycles that must not start a transfer (IDLE, BUSY, or not selected).
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0:       begin HSEL = 1'b0; HTRANS = 2'b10; end
        1:       begin HSEL = 1'b1; HTRANS = 2'b00; end
        default: begin HSEL = 1'b1; HTRANS = 2'b01; end
      endcase
      HADDR = $urandom(); HWRITE = 1'($urandom_range(0, 1)); HSIZE = 3'($urandom_range(0, 2));
      @(posedge HCLK); #1;
    end
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  // Holds reset for three cycles with a write offered at 0x300.
  task automatic reset_seq();
    HRESET = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    HADDR = 32'h300; HWDATA = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); @(negedge HCLK);
      chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("rst_hresp",     32'(HRESP),     32'h0);
      chk("rst_ram_cs",    32'(ram_cs),    32'h0);
      chk("rst_ram_we",    32'(ram_we),    32'h0);
      chk("rst_hrdata",    HRDATA,         32'h0);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
    last_wr_cyc = -10;
  endtask

  // Monitor: checks each data phase cycle and pops on completion.
  logic mon_pending = 1'b0;
  int   mon_waits   = 0;
  always @(negedge HCLK) begin
    exp_t cur;
    logic dp_wr;
    dp_wr = 1'b0;
    if (HRESET) begin
      mon_pending = 1'b0; mon_waits = 0;
    end else begin
      if (mon_pending) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'(sb.size()), 32'h1);
          mon_pending = 1'b0;
        end else begin
          cur = sb[0];
          if (cur.err) begin
            chk("err_hresp", 32'(HRESP), 32'h1);
            chk("err_ram_we", 32'(ram_we), 32'h0);
            if (!HREADYOUT) chk("err1_ram_cs", 32'(ram_cs), 32'h0);
          end else begin
            chk("okay_hresp", 32'(HRESP), 32'h0);
            if (cur.wr) begin
              dp_wr = 1'b1;
              chk("wr_cs_we", 32'({ram_cs, ram_we}), 32'h3);
              chk("wr_addr", 32'(ram_addr), 32'(cur.idx));
              chk("wr_mask", ram_wmask, cur.mask);
              chk("wr_data", ram_wdata, cur.wdata);
            end else if (!HREADYOUT) begin
              chk("stall_cs_we", 32'({ram_cs, ram_we}), 32'h2);
              chk("stall_addr", 32'(ram_addr), 32'(cur.idx));
            end
          end
          if (HREADYOUT) begin
            chk("wait_states", 32'(mon_waits), 32'(cur.waits));
            if (!cur.wr && !cur.err) chk("read_data", HRDATA, cur.rdata);
            else                     chk("hrdata_zero", HRDATA, 32'h0);
            void'(sb.pop_front());
            mon_pending = 1'b0;
          end else begin
            mon_waits++;
            if (mon_waits > 4) begin
              chk("hreadyout_stuck_low", 32'(HREADYOUT), 32'h1);
              void'(sb.pop_front());
              mon_pending = 1'b0;
            end
          end
        end
      end
      if (HSEL && HTRANS[1] && HREADY) begin
        if (!HWRITE && !is_err(HSIZE, HADDR[1:0]) && !dp_wr) begin
          chk("rd_strobe_cs_we", 32'({ram_cs, ram_we}), 32'h2);
          chk("rd_strobe_addr", 32'(ram_addr), 32'(HADDR[14:2]));
        end
        mon_pending = 1'b1; mon_waits = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  lo;
    int          r;
    HWDATA = 32'h0;
    reset_seq();
    idle(2);

    issue(1'b1, 32'h300, 3'd2, 32'h1111_1111, 1'b0);
    idle(2);
    // write then back-to-back read of the same word
    issue(1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h100, 3'd2, 32'h0, 1'b0);
    idle(2);
    // byte lane 3 over a known word, then a non-back-to-back read
    issue(1'b1, 32'h100, 3'd2, 32'h1122_3344, 1'b0);
    idle(1);
    issue(1'b1, 32'h103, 3'd0, 32'hAA00_0000, 1'b0);
    idle(1);
    issue(1'b0, 32'h100, 3'd2, 32'h0, 1'b0);
    idle(2);
    // upper halfword
    issue(1'b1, 32'h200, 3'd2, 32'h1122_3344, 1'b0);
    idle(1);
    issue(1'b1, 32'h202, 3'd1, 32'hBEEF_0000, 1'b0);
    idle(1);
    issue(1'b0, 32'h200, 3'd2, 32'h0, 1'b0);
    idle(2);
    // misaligned word read
    issue(1'b0, 32'h101, 3'd2, 32'h0, 1'b0);
    idle(2);
    // burst of writes then reads
    for (int i = 0; i < 4; i++) issue(1'b1, 32'(4*i), 3'd2, $urandom(), i != 0);
    for (int i = 0; i < 4; i++) issue(1'b0, 32'(4*i), 3'd2, 32'h0, i != 0);
    idle(3);

    // reset with a write offered must leave memory alone
    reset_seq();
    idle(1);
    issue(1'b0, 32'h300, 3'd2, 32'h0, 1'b0);
    idle(2);

    // preload a 64-word window through aliased addresses
    for (int i = 0; i < 64; i++)
      issue(1'b1, ($urandom() & 32'hFFFF_8000) | 32'((32'h400 + i) << 2), 3'd2, $urandom(), 1'b0);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
      lo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) lo = 2'((int'(lo) >> int'(sz)) << int'(sz));
      a = ($urandom() & 32'hFFFF_8000) | 32'((32'h400 + $urandom_range(0, 63)) << 2) | 32'(lo);
      issue(1'($urandom_range(0, 1)), a, sz, $urandom(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    for (int i = 0; i < 20 && (sb.size() != 0 || mon_pending); i++) begin
      @(posedge HCLK); #1;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    foreach (ref_mem[k]) chk("final_mem", ram_model[13'(k)], ref_mem[k]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_ram_bridge.md
# ahb_ram_bridge

- AHB-Lite slave that drives the word-addressed single-port SRAM port (`addr`/`wmask`/`wdata`/`we`/`cs`/`rdata`, 1-cycle registered read) as the initiator on that port.
- Converts AHB byte/halfword/word transfers into masked word writes and zero-wait-state reads.
- Resolves the port conflict when a write data phase overlaps a read address phase, using one wait state.
- Sits between the Cortex-M0 bus matrix and the data RAM.

## Interface
- `ADDR_W`, 13: RAM word-address width. Byte window is 2^(ADDR_W+2); `HADDR` bits above `ADDR_W+1` are ignored (aliasing).

Ports:
- `HCLK` in 1: single clock, rising edge.
- `HRESET` in 1: reset, synchronous, active-high.
- `HSEL` in 1: slave select.
- `HADDR` in 32: byte address.
- `HTRANS` in 2: transfer type; only NONSEQ/SEQ (`HTRANS[1]=1`) start transfers.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: 0 = byte, 1 = half, 2 = word.
- `HWDATA` in 32: write data, lane-positioned, valid in the data phase.
- `HREADY` in 1: bus-level ready.
- `HRDATA` out 32: read data.
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `ram_cs` out 1: RAM select.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out `ADDR_W`: word address, `HADDR[ADDR_W+1:2]`.
- `ram_wmask` out 32: per-bit keep mask; 1 keeps the old bit, 0 takes `ram_wdata`.
- `ram_wdata` out 32: equals `HWDATA`.
- `ram_rdata` in 32: RAM read data, valid the cycle after a read strobe, 0 otherwise.

## Operation
- Accept: `acc = HSEL & HTRANS[1] & HREADY`, sampled at the rising edge.
- FSM states:
  - IDLE: no data phase.
  - RD: read data phase.
  - WR: write data phase.
  - RDSTALL: read captured during WR.
  - ERR1 / ERR2: two-cycle error response.
- Error check on accept: `HSIZE > 2`, or half with `HADDR[0]=1`, or word with `HADDR[1:0]≠0` → ERR1 → ERR2 → next state by new accept. No RAM access is made for an error transfer.
- Read accept, state ≠ WR:
  - In the same (address-phase) cycle drive combinationally `ram_cs=1`, `ram_we=0`, `ram_addr=HADDR[ADDR_W+1:2]`.
  - Next state RD.
- Read accept in WR:
  - Capture the address; next state RDSTALL.
  - RDSTALL cycle: `ram_cs=1`, `ram_we=0`, `ram_addr=captured`.
- Write accept:
  - Register word address, size, and `HADDR[1:0]`; next state WR.
  - WR cycle: `ram_cs=1`, `ram_we=1`, `ram_addr=registered`, `ram_wdata=HWDATA`.
- Lane enables and `ram_wmask = ~{{8{en3}},{8{en2}},{8{en1}},{8{en0}}}`:
  - byte: lane `HADDR[1:0]`.
  - half: lanes {1,0} if `HADDR[1]=0`, else {3,2}.
  - word: all lanes.
- When no RAM access is made: `ram_cs=0`, `ram_we=0`, `ram_wmask=32'hFFFFFFFF`.
- BUSY/IDLE transfers and `HSEL=0`: OKAY, zero wait, no RAM access.
- `HRDATA = ram_rdata` in RD and in the completing cycle after RDSTALL; 0 otherwise.

## Timing
- Reset values (`HRESET=1` at an edge): state IDLE, `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`.
- While `HRESET=1`, `ram_cs` and `ram_we` are forced 0 combinationally. A write data phase coinciding with reset is dropped.
- Read, no conflict: address cycle N, RAM strobe in N; cycle N+1 `HRDATA` valid, `HREADYOUT=1`. Zero wait states.
- Write: address cycle N; cycle N+1 RAM write, `HREADYOUT=1`. Memory updated at the N+1→N+2 edge.
- Write then read back-to-back:
  - N+1: write data phase plus read address phase.
  - N+2: RAM read, `HREADYOUT=0`.
  - N+3: `HRDATA` valid, `HREADYOUT=1`.
  - A read of the same address returns the new data.
- No accept occurs while `HREADYOUT=0`, because `HREADY` is low.
- Write→write, read→read, read→write: no wait states.
- Error: ERR1 gives `HREADYOUT=0`, `HRESP=1`; ERR2 gives `HREADYOUT=1`, `HRESP=1`. A transfer accepted during ERR2 proceeds normally.

## Test plan
- Reset: hold `HRESET=1` for 3 cycles with `HSEL=1`, write NONSEQ → `HREADYOUT=1`, `HRESP=0`, `ram_cs=0` throughout; memory unchanged.
- Word write `0xDEADBEEF` to 0x100, then word read 0x100 → `ram_addr=0x40`, `ram_wmask=0`; read returns `0xDEADBEEF` after exactly one wait state (back-to-back).
- Byte write `0x000000AA` at 0x103 (`HWDATA=0xAA000000`) over word `0x11223344` → `ram_wmask=0x00FFFFFF`; readback `0xAA223344`, zero wait state when not back-to-back.
- Half write `0xBEEF` at 0x202 over `0x11223344` → `ram_wmask=0x0000FFFF`; readback `0xBEEF3344`.
- Misaligned word read at 0x101 → ERR1 (`HREADYOUT=0`, `HRESP=1`), ERR2 (`HREADYOUT=1`, `HRESP=1`), `ram_cs=0` in both cycles.
- Pipelined burst of 4 SEQ word writes to 0x0–0xC, then 4 reads → no wait states except a single one on the first read; data matches.
